// File: rtl/bsg_link_ddr_downstream_sipo.sv
// Link receive stage: reassembles channel beats into core words, buffers them in a FWFT FIFO,
// and returns toggle-encoded credit tokens. Optional stats counters under BSG_LINK_DS_STATS_EN.
module bsg_link_ddr_downstream_sipo #(
  parameter int CHANNEL_WIDTH    = 8,
  parameter int NUM_CHANNELS     = 2,
  parameter int CORE_WIDTH       = 64,
  parameter int FIFO_ELS         = 16,
  parameter int TOKEN_DECIMATION = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNELS-1:0]                io_valid_i,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]  io_data_i,
  output logic                                   core_valid_o,
  output logic [CORE_WIDTH-1:0]                  core_data_o,
  input  logic                                   core_yumi_i,
  output logic                                   token_o,
  output logic                                   err_o
`ifdef BSG_LINK_DS_STATS_EN
  , output logic [31:0]                          words_rcvd_o
  , output logic [15:0]                          words_dropped_o
`endif
);
  localparam int BEAT_W = CHANNEL_WIDTH * NUM_CHANNELS;
  localparam int BEATS  = CORE_WIDTH / BEAT_W;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW     = (FIFO_ELS > 1) ? $clog2(FIFO_ELS) : 1;
  localparam int CW     = $clog2(FIFO_ELS + 1);
  localparam int TW     = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

  logic [BCW-1:0]                       beat_cnt;
  logic [CORE_WIDTH-1:0]                asm_q, word;
  logic [FIFO_ELS-1:0][CORE_WIDTH-1:0]  mem;
  logic [PW-1:0]                        rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0]                        count, count_after_pop, count_n;
  logic [TW-1:0]                        tok_cnt;
  logic beat_ok, skew, last_beat, push_req, pop, full, push, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_ELS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign beat_ok   = &io_valid_i;
  assign skew      = (|io_valid_i) && !beat_ok;
  assign last_beat = (beat_cnt == BCW'(BEATS - 1));
  assign push_req  = beat_ok && last_beat;
  assign pop       = core_yumi_i && core_valid_o;
  assign full      = (count == CW'(FIFO_ELS));
  // A full FIFO still takes the word when the core frees a slot the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign rd_ptr_n        = pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign count_after_pop = count - CW'(pop);
  assign count_n         = count_after_pop + CW'(push);

  always_comb begin
    word = asm_q;
    word[int'(beat_cnt)*BEAT_W +: BEAT_W] = io_data_i;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      asm_q        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      core_valid_o <= 1'b0;
      core_data_o  <= '0;
      tok_cnt      <= '0;
      token_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (beat_ok) begin
        asm_q    <= word;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (skew || drop) err_o <= 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      core_valid_o <= (count_n != '0);
      // Head register: a word landing in an empty FIFO comes straight from the assembler.
      if (count_n != '0)
        core_data_o <= (count_after_pop == '0) ? word : mem[rd_ptr_n];
      if (pop) begin
        if (tok_cnt == TW'(TOKEN_DECIMATION - 1)) begin
          tok_cnt <= '0;
          token_o <= ~token_o;
        end else begin
          tok_cnt <= tok_cnt + 1'b1;
        end
      end
    end
  end

`ifdef BSG_LINK_DS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      words_rcvd_o    <= '0;
      words_dropped_o <= '0;
    end else begin
      if (push && !(&words_rcvd_o))    words_rcvd_o    <= words_rcvd_o + 1'b1;
      if (drop && !(&words_dropped_o)) words_dropped_o <= words_dropped_o + 1'b1;
    end
  end
`endif
endmodule
